// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow result flag.
interface serial_sub_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  ready, busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output ready, busy, done, diff, bout
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial full subtractor: a - b - bin over WIDTH cycles, LSB first.
// Optional signed-overflow output when SERIAL_SUB_OVF_EN is defined.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    serial_sub_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-subtractor cell; returns {borrow_out, difference}.
    function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ready_q, busy_q, done_q;
    logic [1:0]       cell_s;
    logic             d_s;
    logic             bo_s;
    logic [WIDTH-1:0] result_s;

    assign cell_s = fs_cell(sa_q[0], sb_q[0], br_q);
    assign d_s    = cell_s[0];
    assign bo_s   = cell_s[1];

    // The partial-result register holds the upper WIDTH-1 bits already produced.
    generate
        if (WIDTH == 1) begin : g_w1
            assign result_s = d_s;
        end else begin : g_wn
            logic [WIDTH-2:0] sr_q;

            // Partial-result shift register, filled from the top one bit per RUN cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sr_q <= '0;
                end else if (state_q == RUN) begin
                    sr_q <= result_s[WIDTH-1:1];
                end else begin
                    sr_q <= sr_q;
                end
            end

            assign result_s = {d_s, sr_q};
        end
    endgenerate

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1'b1;
                sb_d  = sb_q >> 1'b1;
                br_d  = bo_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = result_s;
                    bout_d  = bo_s;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last bit sa_q[0]/sb_q[0] are the operand sign bits.
                    ovf_d   = (sa_q[0] ^ sb_q[0]) & (d_s ^ sa_q[0]);
`endif
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Overflow flag, updated together with diff.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH=8 and WIDTH=1.
// Define SERIAL_SUB_OVF_EN to include the overflow checks.
module tb_serial_sub;

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst1 = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q1[$];

    serial_sub_if #(.WIDTH(8)) bus8 ();
    serial_sub_if #(.WIDTH(1)) bus1 ();

    serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));
    serial_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // WIDTH=8 monitor
    initial begin
        int   run = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst8) begin
                run = 0;
            end else begin
                if (bus8.busy) run++;
                if (bus8.done) begin
                    if (q8.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL w8_unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
                    end else begin
                        e = q8.pop_front();
                        check("w8_diff", {24'd0, bus8.diff}, e.diff);
                        check("w8_bout", {31'd0, bus8.bout}, {31'd0, e.bout});
`ifdef SERIAL_SUB_OVF_EN
                        check("w8_ovf", {31'd0, bus8.ovf}, {31'd0, e.ovf});
`endif
                        check("w8_done_cycle", cyc, e.cyc);
                        check("w8_busy_cycles", run, 32'd8);
                    end
                    run = 0;
                end
            end
        end
    end

    // WIDTH=1 monitor
    initial begin
        int   run = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst1) begin
                run = 0;
            end else begin
                if (bus1.busy) run++;
                if (bus1.done) begin
                    if (q1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL w1_unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
                    end else begin
                        e = q1.pop_front();
                        check("w1_diff", {31'd0, bus1.diff}, e.diff);
                        check("w1_bout", {31'd0, bus1.bout}, {31'd0, e.bout});
`ifdef SERIAL_SUB_OVF_EN
                        check("w1_ovf", {31'd0, bus1.ovf}, {31'd0, e.ovf});
`endif
                        check("w1_done_cycle", cyc, e.cyc);
                        check("w1_busy_cycles", run, 32'd1);
                    end
                    run = 0;
                end
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] ed, input logic eb, input logic eo, input bit push);
        int n = 0;
        @(negedge clk);
        while (!bus8.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus8.ready) fail_now("w8_wait_ready");
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        bus8.start = 1'b1;
        if (push) q8.push_back('{{24'd0, ed}, eb, eo, cyc + 1 + 8});
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
        bus8.bin   = ~bin;
    endtask

    task automatic issue1(input logic a, input logic b, input logic bin,
                          input logic ed, input logic eb, input logic eo);
        int n = 0;
        @(negedge clk);
        while (!bus1.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus1.ready) fail_now("w1_wait_ready");
        bus1.a     = a;
        bus1.b     = b;
        bus1.bin   = bin;
        bus1.start = 1'b1;
        q1.push_back('{{31'd0, ed}, eb, eo, cyc + 1 + 1});
        @(negedge clk);
        bus1.start = 1'b0;
        bus1.a     = ~a;
        bus1.b     = ~b;
        bus1.bin   = ~bin;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q8.size() != 0 || q1.size() != 0 || !bus8.ready || !bus1.ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now(name);
    endtask

    // Hand-computed WIDTH=1 truth table, indexed by {a,b,bin}.
    logic [7:0] tt_diff = 8'b1001_0110;
    logic [7:0] tt_bout = 8'b1000_1110;
    logic [7:0] tt_ovf  = 8'b0010_0100;

    initial begin
        bus8.start = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0; bus8.bin = 1'b0;
        bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.bin = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        check("rst_ready8", {31'd0, bus8.ready}, 32'd1);
        check("rst_busy8",  {31'd0, bus8.busy},  32'd0);
        check("rst_done8",  {31'd0, bus8.done},  32'd0);
        check("rst_diff8",  {24'd0, bus8.diff},  32'd0);
        check("rst_bout8",  {31'd0, bus8.bout},  32'd0);
        check("rst_ready1", {31'd0, bus1.ready}, 32'd1);
        check("rst_diff1",  {31'd0, bus1.diff},  32'd0);

        issue8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        drain("drain_05_03");
        issue8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1);
        drain("drain_03_05");
        issue8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        drain("drain_00_00_1");
        issue8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1);
        drain("drain_80_01");
        issue8(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
        drain("drain_7f_01");
        issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        drain("drain_ff_ff_1");
        issue8(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
        drain("drain_00_ff");
        issue8(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
        drain("drain_7f_80");

        // start pulsed mid-RUN must be ignored
        issue8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus8.a = 8'h11; bus8.b = 8'h22; bus8.bin = 1'b1; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        drain("drain_ignored_start");
        repeat (12) @(negedge clk);

        // reset mid-RUN abandons the operation without a done pulse
        issue8(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
        drain("drain_pre_reset");
        issue8(8'h80, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check("midrun_rst_ready", {31'd0, bus8.ready}, 32'd1);
        check("midrun_rst_busy",  {31'd0, bus8.busy},  32'd0);
        check("midrun_rst_done",  {31'd0, bus8.done},  32'd0);
        check("midrun_rst_diff",  {24'd0, bus8.diff},  32'd0);
        check("midrun_rst_bout",  {31'd0, bus8.bout},  32'd0);
        repeat (12) @(negedge clk);
        issue8(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1);
        drain("drain_aa_55");

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            issue1(v[2], v[1], v[0], tt_diff[i], tt_bout[i], tt_ovf[i]);
            drain("drain_w1");
        end

        repeat (4) @(negedge clk);
        check("q8_empty", q8.size(), 32'd0);
        check("q1_empty", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial full subtractor: computes a - b - bin over WIDTH cycles, LSB first.
- Uses one full-subtractor cell and a registered borrow.
- Companion to the combinational full adder: the subtraction direction of the same arithmetic datapath.
- Sits between a register-file read and result write-back, with a start/ready/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous active-high reset, sampled on rising edge of clk
start  input  1  request to begin a subtraction; honoured only when ready=1
a  input  WIDTH  minuend; sampled on the accepted start edge only
b  input  WIDTH  subtrahend; sampled on the accepted start edge only
bin  input  1  borrow-in; sampled on the accepted start edge only
ready  output  1  high in IDLE only
busy  output  1  high in RUN only
done  output  1  one-cycle pulse, high in DONE only
diff  output  WIDTH  registered result; holds last completed result
bout  output  1  registered borrow-out of last completed result

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, internal shift registers/count/borrow=0.
- rst overrides everything, including mid-RUN: the operation is abandoned and no done pulse is produced.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge → load sa=a, sb=b, br=bin, cnt=0; next state RUN.
  - start=0 → stay in IDLE.
- RUN (busy=1, ready=0), each edge:
  - d = sa[0]^sb[0]^br
  - br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)
  - sr <= {d, sr[WIDTH-1:1]}; sa, sb shift right by 1; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: diff <= {d, sr[WIDTH-1:1]}, bout <= new borrow; next state DONE.
- DONE:
  - done=1 for exactly one cycle; diff/bout already valid in this cycle.
  - Next edge → IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued. a/b/bin may change freely after acceptance.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- diff/bout change only on completion (or reset); they hold through IDLE and the next RUN.
- Arithmetic: diff = (a - b - bin) mod 2^WIDTH; bout=1 iff a < b + bin (unsigned).
- WIDTH=1: RUN lasts one cycle; the rules above still apply.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (output, 1 bit): the signed two's-complement overflow of a - b - bin.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on the final bit.
  - Registered alongside diff; reset to 0; holds with diff.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x05 b=0x03 bin=0, start one cycle → busy for 8 cycles, done pulse 9 cycles after the start edge, diff=0x02, bout=0.
- a=0x03 b=0x05 bin=0 → diff=0xFE, bout=1. Then a=0x00 b=0x00 bin=1 → diff=0xFF, bout=1.
- a=0x80 b=0x01 bin=0 → diff=0x7F, bout=0, ovf=1 (macro defined). a=0x7F b=0x01 → diff=0x7E, ovf=0.
- Pulse start again at cycle 3 of RUN with different operands → ignored; result and done timing match the first operation only.
- Assert rst at cycle 4 of RUN → next cycle ready=1, busy=0, diff=0, bout=0, no done pulse. Then a=0xAA b=0x55 bin=0 → diff=0x55, bout=0.
- WIDTH=1: all 8 combinations of a,b,bin → {bout,diff} equals the full-subtractor truth table (e.g. 0,1,1 → bout=1 diff=0; 1,0,0 → bout=0 diff=1). Each done pulse occurs 2 cycles after the start edge.
